// File: rtl/bird_motion.sv
// Flappy-bird game-state and vertical-physics engine. State and position change on frame_tick;
// a pipe collision ends the flight on any cycle.
module bird_motion #(
  parameter logic        [9:0] StartY   = 10'd220,
  parameter logic        [9:0] BirdH    = 10'd20,
  parameter logic        [9:0] FloorY   = 10'd480,
  parameter logic signed [7:0] Gravity  = 8'sd1,
  parameter logic signed [7:0] FlapV    = 8'sd8,
  parameter logic signed [7:0] MaxFall  = 8'sd10,
  parameter logic        [5:0] DeadHold = 6'd60
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_tick_i,
  input  logic              flap_btn_i,
  input  logic              collide_i,
  output logic [9:0]        bird_y_o,
  output logic signed [7:0] bird_vel_o,
  output logic [1:0]        state_o,
  output logic              game_over_o
);

  typedef enum logic [1:0] {StReady = 2'b00, StFlying = 2'b01, StDead = 2'b10, StBad = 2'b11}
    state_e;

  localparam logic [9:0] BottomY = FloorY - BirdH;

  state_e             state_q, state_d;
  logic [9:0]         y_q, y_d;
  logic signed [7:0]  vel_q, vel_d;
  logic [5:0]         hold_q, hold_d;
  logic               pend_q, pend_d;
  logic [1:0]         sync_q;
  logic               prev_q;

  logic               flap_rise;
  logic signed [7:0]  vel_inc, new_vel;
  logic signed [10:0] ny;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StReady;
      y_q     <= StartY;
      vel_q   <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      sync_q  <= {sync_q[0], flap_btn_i};
      prev_q  <= sync_q[1];
    end
  end

  assign flap_rise = sync_q[1] & ~prev_q;

  always_comb begin
    vel_inc = vel_q + Gravity;
    new_vel = pend_q ? -FlapV : ((vel_inc > MaxFall) ? MaxFall : vel_inc);
    // 11-bit signed sum so an overshoot above the ceiling shows up as negative
    ny      = $signed({1'b0, y_q}) + $signed({{3{new_vel[7]}}, new_vel});

    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    hold_d  = hold_q;
    pend_d  = pend_q | flap_rise;

    case (state_q)
      StReady: begin
        if (frame_tick_i && pend_q) begin
          state_d = StFlying;
          vel_d   = -FlapV;
          y_d     = StartY - {2'b00, FlapV};
          pend_d  = 1'b0;
        end
      end
      StFlying: begin
        if (collide_i) begin
          state_d = StDead;
          hold_d  = '0;
        end else if (frame_tick_i) begin
          pend_d = 1'b0;
          if (ny[10]) begin
            y_d   = '0;
            vel_d = '0;
          end else if (ny[9:0] >= BottomY) begin
            y_d     = BottomY;
            vel_d   = '0;
            state_d = StDead;
            hold_d  = '0;
          end else begin
            y_d   = ny[9:0];
            vel_d = new_vel;
          end
        end
      end
      StDead: begin
        if (hold_q != DeadHold) begin
          pend_d = 1'b0;
          if (frame_tick_i) hold_d = hold_q + 6'd1;
        end else if (frame_tick_i && pend_q) begin
          state_d = StReady;
          y_d     = StartY;
          vel_d   = '0;
          hold_d  = '0;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = StReady;
        y_d     = StartY;
        vel_d   = '0;
        hold_d  = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    bird_y_o    = y_q;
    bird_vel_o  = vel_q;
    state_o     = state_q;
    game_over_o = (state_q == StDead);
  end

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: reset, start, free fall, ceiling, collide and restart.
module tb_bird_motion;

  logic              clk = 1'b0;
  logic              rst, frame_tick, flap_btn, collide;
  logic [9:0]        bird_y;
  logic signed [7:0] bird_vel;
  logic [1:0]        state;
  logic              game_over;

  int checks = 0;
  int errors = 0;

  bird_motion dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_tick_i (frame_tick),
    .flap_btn_i   (flap_btn),
    .collide_i    (collide),
    .bird_y_o     (bird_y),
    .bird_vel_o   (bird_vel),
    .state_o      (state),
    .game_over_o  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int y, input int vel, input int st);
    check({tag, "_y"}, int'(bird_y), y);
    check({tag, "_vel"}, int'(bird_vel), vel);
    check({tag, "_st"}, int'(state), st);
    check({tag, "_go"}, int'(game_over), (st == 2) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic tick_collide();
    @(negedge clk) begin frame_tick = 1'b1; collide = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; collide = 1'b0; end
  endtask

  task automatic flap();
    @(negedge clk) flap_btn = 1'b1;
    repeat (4) @(negedge clk);
    flap_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_game();
    do_reset();
    flap();
    tick();
  endtask

  int n;

  initial begin
    rst = 1'b0; frame_tick = 1'b0; flap_btn = 1'b0; collide = 1'b0;

    // Reset and idle READY
    do_reset();
    check_all("reset", 220, 0, 0);
    repeat (3) tick();
    check_all("ready_idle", 220, 0, 0);

    // Start and first free-flight frames
    flap();
    tick();
    check_all("start", 212, -8, 1);
    tick(); check("t1_y", int'(bird_y), 205);
    tick(); check("t2_y", int'(bird_y), 199);
    tick(); check_all("t3", 194, -5, 1);

    // Free fall to the floor
    start_game();
    repeat (18) tick();
    check_all("fall18", 239, 10, 1);
    n = 0;
    while (state != 2'b10 && n < 50) begin
      tick();
      n++;
    end
    check("fall_ticks", n, 23);
    check_all("floor", 460, 0, 2);

    // Ceiling clamp
    start_game();
    repeat (24) begin flap(); tick(); end
    check_all("ceil20", 20, -8, 1);
    flap(); tick(); check("ceil12_y", int'(bird_y), 12);
    flap(); tick(); check("ceil4_y", int'(bird_y), 4);
    flap(); tick(); check_all("ceil0", 0, 0, 1);
    tick(); check_all("ceil_after", 1, 1, 1);

    // Collide coincident with tick at y=150
    start_game();
    repeat (4) tick();
    check_all("pre150", 190, -4, 1);
    repeat (5) begin flap(); tick(); end
    check_all("at150", 150, -8, 1);
    tick_collide();
    check_all("collide", 150, -8, 2);

    // Restart hold-off
    repeat (30) tick();
    flap(); tick();
    check_all("dead31", 150, -8, 2);
    repeat (28) tick();
    flap(); tick();
    check_all("dead60", 150, -8, 2);
    tick();
    check_all("dead61", 150, -8, 2);
    flap(); tick();
    check_all("restart", 220, 0, 0);

    // Hold counter restarts from zero on a new death
    flap(); tick();
    check_all("restart_fly", 212, -8, 1);
    @(negedge clk) collide = 1'b1;
    @(negedge clk) collide = 1'b0;
    check_all("collide_notick", 212, -8, 2);
    flap(); tick();
    check_all("hold_cleared", 212, -8, 2);

    // Collide ignored in READY
    do_reset();
    tick_collide();
    check_all("ready_collide", 220, 0, 0);

    // Reset mid-flight
    start_game();
    tick();
    check("mid_y", int'(bird_y), 205);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_all("mid_reset", 220, 0, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
